// File: rtl/seq_match_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_detector_pkg
// Description : Shared FSM encodings and parameter defaults for the serial
//               pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_match_detector_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam int         c_DEF_PATTERN_LEN = 4;
    localparam logic [3:0] c_DEF_PATTERN     = 4'b1011;
    localparam int         c_DEF_CNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/seq_match_detector_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2_reg
// Description : Two-flop single-bit register chain for d_ff stage consumers.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2_reg (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            q    <= 1'b0;
        end else begin
            r_s1 <= d;
            q    <= r_s1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_match_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_detector
// Description : Serial pattern detector with fill-tracking FSM, registered
//               match pulse and saturating hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_detector
    import seq_match_detector_pkg::*;
#(
    parameter int                     PATTERN_LEN = c_DEF_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = c_DEF_PATTERN,
    parameter int                     CNT_W       = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             sample_en,
    input  logic             clear_cnt,
    output logic             din_sync,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state
);

    localparam int                  c_FILL_W  = $clog2(PATTERN_LEN + 1);
    localparam logic [c_FILL_W-1:0] c_FULL    = c_FILL_W'(PATTERN_LEN);
    localparam logic [CNT_W-1:0]    c_CNT_MAX = '1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_FILL_W-1:0]    r_fill;
    logic [c_FILL_W-1:0]    w_next_fill;
    logic [PATTERN_LEN-2:0] r_hist;
    logic [PATTERN_LEN-1:0] w_next_window;
    logic                   r_match;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_sat;

    sync2_reg u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (din_sync)
    );

    // Only the older PATTERN_LEN-1 bits are stored; the newest is din_sync.
    assign w_next_window = {r_hist, din_sync};

    always_comb begin
        w_next_state = r_state;
        w_next_fill  = r_fill;
        if (r_state == ST_ILLEGAL) begin
            w_next_state = ST_EMPTY;
            w_next_fill  = '0;
        end else if (sample_en) begin
            case (r_state)
                ST_EMPTY: begin
                    w_next_state = ST_FILLING;
                    w_next_fill  = c_FILL_W'(1);
                end
                ST_FILLING: begin
                    w_next_fill = r_fill + c_FILL_W'(1);
                    if (w_next_fill == c_FULL) begin
                        w_next_state = ST_ARMED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Clear wins over a coincident increment, so that hit is dropped.
    always_comb begin
        w_cnt_next = r_cnt;
        if (clear_cnt) begin
            w_cnt_next = '0;
        end else if (r_match && (r_cnt != c_CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_fill  <= '0;
            r_hist  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_fill  <= w_next_fill;
            if (sample_en) begin
                r_hist <= w_next_window[PATTERN_LEN-2:0];
            end
            r_match <= sample_en && (w_next_window == PATTERN)
                       && (w_next_state == ST_ARMED);
            r_cnt   <= w_cnt_next;
            r_sat   <= (w_cnt_next == c_CNT_MAX);
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: doc/seq_match_detector.md
Name: seq_match_detector

Overview:
- Serial-bitstream consumer that sits directly downstream of the d_ff stage.
- Takes the single-bit registered data line `din`, re-registers it through a two-flop chain, and shifts it into a PATTERN_LEN-bit window.
- Raises a one-cycle `match` pulse whenever the most recent PATTERN_LEN sampled bits equal PATTERN. Overlapping matches count.
- Keeps a saturating count of matches for status/debug readout.

Parameters:
- PATTERN_LEN, 4, number of bits in the window; legal range 2..16.
- PATTERN, 4'b1011, target sequence. The MSB is the oldest bit and the LSB is the newest.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- sample_en  input  1  when high, the current din_sync bit is shifted into the window at this edge.
- clear_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
- din_sync  output  1  second stage of the input register chain.
- match  output  1  one-cycle pulse on a pattern hit.
- match_cnt  output  CNT_W  saturating count of hits.
- cnt_sat  output  1  high while match_cnt equals all-ones.
- state  output  2  FSM state, for debug.

Behaviour:
- **Input chain:** s1 <= din; din_sync <= s1. This chain is unconditional and does not depend on sample_en.
- **Window shift:** on an edge with sample_en=1, window <= {window[PATTERN_LEN-2:0], din_sync}. With sample_en=0, the window, fill counter and FSM all hold.
- **FSM states:**
  - EMPTY (2'd0): fill=0.
  - FILLING (2'd1): 0 < fill < PATTERN_LEN.
  - ARMED (2'd2): fill == PATTERN_LEN.
  - 2'd3 is illegal and recovers to EMPTY on the next edge.
- **FSM transitions (only on edges with sample_en=1):**
  - EMPTY -> FILLING, fill=1.
  - FILLING -> FILLING with fill+1, or -> ARMED when fill+1 == PATTERN_LEN.
  - ARMED -> ARMED; fill saturates.
- **Match:** match <= sample_en && (next_window == PATTERN) && (next_state == ARMED).
  - match is registered, so it is high for exactly the one cycle after the edge that shifted in the completing bit.
  - A bit shifted in while the FSM is not yet ARMED can never produce a match, even if stale window bits happen to line up.
- **Latency:** 3 rising edges from din to match, with sample_en held high: edge 1 loads s1, edge 2 loads din_sync, edge 3 shifts the window and registers match.
- **Overlap:** the window is not cleared on a match, so back-to-back overlapping hits each pulse. Example: 1011011 gives 2 pulses.
- **Counter:**
  - On each match pulse (registered, one cycle later), match_cnt increments by 1 unless it is already all-ones.
  - cnt_sat = (match_cnt == all-ones), registered in the same cycle as the counter.
- **clear_cnt:**
  - clear_cnt has priority over a simultaneous increment: the result is match_cnt=0, cnt_sat=0, and that hit is lost.
  - clear_cnt does not affect the window, FSM or match.
- **Reset:** every output and internal register goes to 0: s1, din_sync, window, fill, state=EMPTY, match, match_cnt, cnt_sat.
  - reset beats sample_en and clear_cnt.
  - A partial pattern in flight when reset asserts is discarded; the fill restarts from EMPTY.
- **Arithmetic:** fill is $clog2(PATTERN_LEN+1) bits wide. All compares are unsigned and there is no wrap.

Decomposition:
- Shared package holds:
  - State encodings ST_EMPTY=2'd0, ST_FILLING=2'd1, ST_ARMED=2'd2.
  - Defaults for PATTERN_LEN, PATTERN and CNT_W.
- One natural sub-module: sync2_reg, the two-flop input chain (clk, reset, d, q). It is reusable by other single-bit consumers of d_ff outputs.
- Window, FSM and counter stay in the top module.

Test Plan:
1. **Reset values:** assert reset for 2 cycles with din=1 -> all outputs 0 and state=0. After release with sample_en=0, state stays 0, and din_sync=1 two edges after release.
2. **Basic hit:** sample_en=1, din driven 1,0,1,1 on consecutive cycles -> exactly one match pulse, 3 edges after the last bit is applied. match_cnt then reads 1 and state reads 2.
3. **Overlap:** stream 1,0,1,1,0,1,1 -> two match pulses 3 cycles apart, match_cnt=2. Also stream 1,1,1,1 -> no pulse.
4. **Stall:** same stream as scenario 2, with sample_en deasserted for 2 cycles between bits 2 and 3 while din holds steady -> exactly one hit, delayed by 2 cycles; the duplicated held value is not shifted.
5. **Clear and saturation:**
   - With CNT_W=2, produce 4 hits -> match_cnt sticks at 3, cnt_sat=1.
   - clear_cnt pulsed in the same cycle as a match pulse -> match_cnt=0, cnt_sat=0.
6. **Reset mid-pattern:** shift 1,0,1, assert reset one cycle, then shift a single 1 -> no match, state=FILLING with fill=1.
